modulo_medidor_frequencia: RTL and testbench
============================================

Name: modulo_medidor_frequencia

Overview:
- Frequency meter that consumes a slow square wave, such as one tap of the 20-stage ripple divider chain or an external test signal.
- Counts rising edges of `sig_in` over a gate window of `GATE_CYCLES` system-clock cycles and reports the count.
- Used to check divider taps on hardware and to feed the display path.
- Start/busy/valid handshake toward the controlling FSM.

Parameters:
- GATE_CYCLES, 1000, length of the measurement window in `clk` cycles; legal range 2 to 2^24-1.
- CNT_W, 20, width of the edge counter and the `freq` result.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  reset; asynchronous, active-high; clears all state.
- start  input  1  request a measurement; sampled only in IDLE.
- sig_in  input  1  asynchronous signal under measurement.
- freq  output  CNT_W  rising-edge count of the last completed window.
- valid  output  1  one-cycle pulse when `freq` is updated.
- busy  output  1  high while a measurement window is open.
- ovf  output  1  edge count of the last completed window saturated.

Behaviour:
- Reset (`clr`=1, asynchronous):
  - State goes to IDLE.
  - `freq`, `valid`, `busy`, `ovf`, edge counter, gate timer and all synchronizer/edge flops go to 0.
  - Takes effect immediately, independent of `clk`.
- Input conditioning:
  - `sig_in` passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - `edge_det` = s2 & ~s3.
  - Latency from a `sig_in` rising transition to `edge_det`: 2–3 cycles.
  - The conditioning chain runs in every state.
  - `sig_in` already high at reset release yields one `edge_det`.
  - Pulses shorter than one `clk` period may be missed; `sig_in` must stay high ≥2 and low ≥2 cycles to be counted reliably.
- State machine, IDLE:
  - `busy`=0.
  - On the clock edge where `start`=1: clear the edge counter and gate timer, go to MEASURE.
- State machine, MEASURE:
  - `busy`=1 for exactly `GATE_CYCLES` cycles; gate timer counts 0 to GATE_CYCLES-1.
  - Each MEASURE cycle with `edge_det`=1 increments the edge counter.
  - The counter saturates at 2^CNT_W-1; an `edge_det` while saturated sets an internal overflow flag.
  - At the end of the cycle with timer = GATE_CYCLES-1:
    - `freq` <= counter, including that cycle's edge;
    - `ovf` <= overflow flag;
    - `valid` <= 1;
    - state goes to IDLE.
- `valid` is high for exactly one cycle (the first IDLE cycle).
- `freq` and `ovf` hold until the next completed window or reset.
- `start`:
  - ignored while `busy`=1, with no queuing;
  - `start`=1 in the `valid` cycle is accepted, so back-to-back windows leave a gap of one IDLE cycle.
- Edges arriving in IDLE are never counted.
- Reset mid-window aborts the measurement: no `valid`, and `freq`/`ovf` are 0 after reset.
- Result semantics: f_sig = freq × f_clk / GATE_CYCLES, with quantisation ±1 count.

Test Plan (GATE_CYCLES=100, CNT_W=20 unless stated):
- Assert `clr` asynchronously between clock edges → all outputs 0 immediately; `start` held low → `busy` stays 0, no `valid`.
- `sig_in` period 4 `clk` (2 high/2 low) running before `start` → `busy` high 100 cycles, then one-cycle `valid`, `freq`=25 ±1, `ovf`=0.
- `sig_in` held constant low, then constant high from before `start` → `freq`=0 both times, `valid` pulses once each.
- CNT_W=4, `sig_in` period 4 → counter saturates at 15, `freq`=15, `ovf`=1; next window with `sig_in` period 40 → `freq`=2 or 3, `ovf`=0.
- Pulse `clr` at cycle 50 of a window → `busy` drops immediately, no `valid` follows, `freq`=0; a new `start` then completes normally.
- `start` pulsed at cycle 30 of a window → ignored, and window length stays 100; `start` held high continuously → windows repeat every 101 cycles, each with one `valid` pulse.

Source files
------------

// File: rtl/modulo_medidor_frequencia.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clk cycles and reports the saturated count.
module modulo_medidor_frequencia #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             edge_det;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf_flag, ovf_nxt;
  logic [TW-1:0]    timer;

  assign edge_det = s2 & ~s3;

  // Next counter value including this cycle's edge, so the closing cycle's
  // edge lands in freq without an extra pipeline stage.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf_flag;
    if (edge_det) begin
      if (&cnt) ovf_nxt = 1'b1;
      else      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      timer    <= '0;
      freq     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            ovf_flag <= 1'b0;
            timer    <= '0;
            busy     <= 1'b1;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          cnt      <= cnt_nxt;
          ovf_flag <= ovf_nxt;
          if (timer == TW'(GATE_CYCLES - 1)) begin
            freq  <= cnt_nxt;
            ovf   <= ovf_nxt;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_medidor_frequencia.sv
// Bench for modulo_medidor_frequencia: two instances (CNT_W=20 and CNT_W=4)
// share stimulus; a sample-history reference model feeds result scoreboards.
module tb_modulo_medidor_frequencia;

  localparam int unsigned G = 100;
  localparam int unsigned HMAX = 8192;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        sig_in = 1'b0;
  logic [19:0] freq20;
  logic [3:0]  freq4;
  logic        valid20, valid4, busy20, busy4, ovf20, ovf4;

  modulo_medidor_frequencia #(.GATE_CYCLES(G), .CNT_W(20)) dut20 (
    .clk(clk), .clr(clr), .start(start), .sig_in(sig_in),
    .freq(freq20), .valid(valid20), .busy(busy20), .ovf(ovf20)
  );

  modulo_medidor_frequencia #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .clr(clr), .start(start), .sig_in(sig_in),
    .freq(freq4), .valid(valid4), .busy(busy4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned f;
    bit          o;
  } res_t;

  res_t q20[$];
  res_t q4[$];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: the value of sig_in seen at every rising edge (0 while
  // clr holds the synchronizer). A rising edge is credited to the window
  // cycle two edges after it was first sampled high.
  bit          hist [HMAX];
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          w_start = 0;
  res_t        held20 = '{0, 1'b0};
  res_t        held4  = '{0, 1'b0};

  function automatic int unsigned edges_in_window(input int k);
    int unsigned n = 0;
    for (int m = k + 1; m <= k + int'(G); m++)
      if (m >= 3 && hist[m-2] && !hist[m-3]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    int unsigned n;
    res_t r;
    cyc++;
    if (cyc < int'(HMAX)) hist[cyc] = clr ? 1'b0 : sig_in;
    m_valid = 1'b0;
    if (clr) begin
      m_busy = 1'b0;
      held20 = '{0, 1'b0};
      held4  = '{0, 1'b0};
    end else if (!m_busy) begin
      if (start) begin
        m_busy  = 1'b1;
        w_start = cyc;
      end
    end else if (cyc == w_start + int'(G)) begin
      n = edges_in_window(w_start);
      r.f = (n > 20'hFFFFF) ? 20'hFFFFF : n;
      r.o = (n > 20'hFFFFF);
      q20.push_back(r);
      held20 = r;
      r.f = (n > 15) ? 15 : n;
      r.o = (n > 15);
      q4.push_back(r);
      held4 = r;
      m_busy  = 1'b0;
      m_valid = 1'b1;
    end
  end

  // Monitor: pops on valid, continuously checks handshake and held results.
  always @(negedge clk) begin
    res_t r;
    if (valid20) begin
      if (q20.size() == 0) chk("unexpected_valid20", 1, 0);
      else begin
        r = q20.pop_front();
        chk("freq20", freq20, r.f);
        chk("ovf20", ovf20, r.o);
      end
    end
    if (valid4) begin
      if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
      else begin
        r = q4.pop_front();
        chk("freq4", freq4, r.f);
        chk("ovf4", ovf4, r.o);
      end
    end
    chk("busy20", busy20, m_busy);
    chk("busy4", busy4, m_busy);
    chk("valid20", valid20, m_valid);
    chk("valid4", valid4, m_valid);
    chk("hold_freq20", freq20, held20.f);
    chk("hold_ovf4", ovf4, held4.o);
    chk("hold_freq4", freq4, held4.f);
  end

  // Stimulus: sig_in generator modes: 0 low, 1 high, 2 fixed half period, 3 random.
  int unsigned mode = 0;
  int unsigned hp = 2;
  int unsigned hcnt = 0;

  task automatic gen_sig();
    case (mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      default: begin
        if (hcnt <= 1) begin
          sig_in = ~sig_in;
          hcnt = (mode == 2) ? hp : $urandom_range(2, 6);
        end else hcnt--;
      end
    endcase
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      gen_sig();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {busy20, busy4}, 0);
    chk({tag, "_valid"}, {valid20, valid4}, 0);
    chk({tag, "_freq20"}, freq20, 0);
    chk({tag, "_freq4_ovf"}, {freq4, ovf20, ovf4}, 0);
  endtask

  initial begin
    #1 chk_all_zero("por");
    tick(3);
    clr = 1'b0;
    tick(12);

    // Period 4 square wave: 25 edges, saturates the 4-bit instance.
    mode = 2; hp = 2;
    tick(7);
    pulse_start();
    tick(G + 5);

    // Period 40: 2 or 3 edges, clears the overflow.
    hp = 20;
    tick(13);
    pulse_start();
    tick(G + 5);

    // Constant low, then constant high.
    mode = 0;
    tick(5);
    pulse_start();
    tick(G + 5);
    mode = 1;
    tick(5);
    pulse_start();
    tick(G + 5);

    // Run a window so results are nonzero, then abort the next one mid-way.
    mode = 2; hp = 2;
    pulse_start();
    tick(G + 5);
    pulse_start();
    tick(49);
    #2 clr = 1'b1;
    #1 chk_all_zero("async_clr");
    tick(2);
    clr = 1'b0;
    tick(G + 10);
    pulse_start();
    tick(G + 5);

    // Start re-pulsed inside a window must not stretch it.
    mode = 3;
    pulse_start();
    tick(29);
    pulse_start();
    tick(G);

    // Start held high: back-to-back windows.
    start = 1'b1;
    tick(3 * (G + 1) + 20);
    start = 1'b0;
    tick(G + 5);

    // Randomized windows.
    for (int i = 0; i < 6; i++) begin
      mode = $urandom_range(0, 3);
      hp = $urandom_range(2, 25);
      tick($urandom_range(1, 20));
      pulse_start();
      tick(G + 2);
    end
    tick(5);

    chk("q20_drained", q20.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
